intersection_light_sequencer: RTL and testbench
===============================================

// Module: intersection_light_sequencer
// PURPOSE
//  Parametrised next-generation intersection light controller. One instance serves NUM_ROADS approaches round-robin.
//  Only one road is ever non-red. Each road gets an all-red clearance interval before its own phases.
//  Adds pedestrian-request latching, a sticky fault-flash mode and status outputs.
//  Sits between the board clock/reset/buttons and the per-road lamp drivers.
// PARAMETERS
//  NUM_ROADS  2           number of approaches served, >=2
//  TICK_DIV   50_000_000  clock cycles per 1 s timing tick
//  TIME_W     8           width of phase-duration counter, in ticks
//  ALLRED_S   2           all-red clearance, ticks
//  LEFT_S     10          left-turn arrow, ticks
//  PED_S      10          green + walk portion, ticks; must be < GREEN_S
//  GREEN_S    20          total green time incl. walk portion, ticks
//  YELLOW_S   5           yellow time, ticks
//  FLASH_DIV  25_000_000  cycles per half-period of fault flash
// PORTS
//  in_clock        in   1          board clock, all logic on posedge
//  in_reset_n      in   1          asynchronous, active-low reset
//  in_issue        in   1          fault request, sampled synchronously; sticky once taken
//  in_ped_request  in   NUM_ROADS  walk-button pulses, one bit per road (TLS_PED_REQUEST_EN only)
//  out_red         out  NUM_ROADS  red lamp per road
//  out_yellow      out  NUM_ROADS  yellow lamp per road
//  out_green       out  NUM_ROADS  green lamp per road
//  out_left_turn   out  NUM_ROADS  left-arrow lamp per road
//  out_pedestrian  out  NUM_ROADS  walk lamp per road
//  out_active_road out  RW=max(1,$clog2(NUM_ROADS))  road currently being served
//  out_state       out  3          ALL_RED=0, LEFT_TURN=1, GREEN_PEDES=2, GREEN=3, YELLOW=4, ISSUE=5
//  out_fault       out  1          high while in ISSUE
// BEHAVIOUR
//  - Reset (async assert, sync use after release):
//    state=ALL_RED, road=0, prescaler=0, phase count=0, ped latches=0, flash=1.
//    Outputs: out_red=all 1; every other lamp=0; out_active_road=0; out_fault=0.
//  - Moore machine. Lamps decode registered state/road/flash only, so they change the cycle after a transition.
//  - Timing:
//    - Prescaler counts 0..TICK_DIV-1 and pulses a tick at TICK_DIV-1.
//    - Phase counter (TIME_W bits) increments on each tick.
//    - A phase ends on the tick where phase count == dur-1.
//    - Both counters clear on every state change, so a phase lasts exactly dur*TICK_DIV cycles.
//  - Sequence for the active road r:
//    - ALL_RED(ALLRED_S) -> LEFT_TURN(LEFT_S).
//    - Then GREEN_PEDES(PED_S) if ped_latch[r], else skip straight to GREEN.
//    - GREEN lasts GREEN_S-PED_S after GREEN_PEDES, otherwise GREEN_S.
//    - Then YELLOW(YELLOW_S).
//    - Then ALL_RED with road = (r==NUM_ROADS-1) ? 0 : r+1, wrapping.
//  - Lamps for road r:
//    - LEFT_TURN: left=1.
//    - GREEN_PEDES: green=1, ped=1.
//    - GREEN: green=1.
//    - YELLOW: yellow=1.
//    - All other roads: red=1, all else 0.
//    - ALL_RED: every road red only.
//  - Ped latch: bit set by an in_ped_request pulse; bit[r] cleared on the LEFT_TURN->GREEN_PEDES edge.
//    If set and clear coincide, set wins: the request is served on the road's next turn.
//  - ISSUE:
//    - Entered on the first edge with in_issue=1, from any state, with priority over all phase transitions.
//    - All green/yellow/left/ped lamps=0; every out_red = flash.
//    - Flash starts at 1 and toggles every FLASH_DIV cycles.
//    - out_fault=1. Ped latches are held.
//    - Left only by in_reset_n=0; deasserting in_issue has no effect.
//  - Reset mid-phase aborts immediately to the reset values; no yellow is forced.
//  - Durations must satisfy 1 <= dur < 2^TIME_W. Exceeding this is a configuration error and is not checked in RTL.
// CONFIGURATION
//  TLS_PED_REQUEST_EN
//  - Defined: the in_ped_request port and ped latches exist; GREEN_PEDES is entered only on request.
//  - Undefined: the port is absent and the latches are removed.
//    Every road always runs GREEN_PEDES(PED_S) then GREEN(GREEN_S-PED_S).
// TESTING
//  Params: NUM_ROADS=2, TICK_DIV=4, ALLRED_S=1, LEFT_S=2, PED_S=2, GREEN_S=4, YELLOW_S=1, FLASH_DIV=3.
//  1 No requests, macro on. After reset release, road0 shows ALL_RED 4 cycles, left 8, green 16, yellow 4.
//    Then out_active_road=1 and ALL_RED; the full loop is 64 cycles.
//  2 Pulse in_ped_request[1] during road0 GREEN. Road1 shows left 8 cycles, green+ped 8, green 8, yellow 4.
//    ped_latch[1] then reads 0.
//  3 in_issue=1 mid road0 GREEN. Next cycle: out_state=5, out_fault=1, greens=0.
//    out_red toggles 11 -> 00 every 3 cycles. Dropping in_issue holds ISSUE; in_reset_n=0 gives ALL_RED, road0.
//  4 in_reset_n=0 mid road1 YELLOW. Same cycle: out_red=11, out_yellow=00, out_active_road=0, with no clock edge needed.
//  5 NUM_ROADS=3: road2 YELLOW end -> out_active_road=0, ALL_RED (wrap).
//  6 in_ped_request[0] on the same edge that clears ped_latch[0]. GREEN_PEDES still runs now, latch stays 1,
//    and the next road0 turn also gets GREEN_PEDES.

Source files
------------

// File: rtl/intersection_light_sequencer.sv
// Round-robin intersection light controller with sticky fault-flash mode.
// Optional pedestrian-request latching is enabled by defining TLS_PED_REQUEST_EN.
module intersection_light_sequencer #(
  parameter int NUM_ROADS = 2,
  parameter int TICK_DIV  = 50_000_000,
  parameter int TIME_W    = 8,
  parameter int ALLRED_S  = 2,
  parameter int LEFT_S    = 10,
  parameter int PED_S     = 10,
  parameter int GREEN_S   = 20,
  parameter int YELLOW_S  = 5,
  parameter int FLASH_DIV = 25_000_000,
  localparam int RW = (NUM_ROADS > 2) ? $clog2(NUM_ROADS) : 1
) (
  input  logic                 in_clock,
  input  logic                 in_reset_n,
  input  logic                 in_issue,
`ifdef TLS_PED_REQUEST_EN
  input  logic [NUM_ROADS-1:0] in_ped_request,
`endif
  output logic [NUM_ROADS-1:0] out_red,
  output logic [NUM_ROADS-1:0] out_yellow,
  output logic [NUM_ROADS-1:0] out_green,
  output logic [NUM_ROADS-1:0] out_left_turn,
  output logic [NUM_ROADS-1:0] out_pedestrian,
  output logic [RW-1:0]        out_active_road,
  output logic [2:0]           out_state,
  output logic                 out_fault
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [PW-1:0]     TICK_LAST       = PW'(TICK_DIV - 1);
  localparam logic [FW-1:0]     FLASH_LAST      = FW'(FLASH_DIV - 1);
  localparam logic [TIME_W-1:0] ALLRED_END      = TIME_W'(ALLRED_S - 1);
  localparam logic [TIME_W-1:0] LEFT_END        = TIME_W'(LEFT_S - 1);
  localparam logic [TIME_W-1:0] PED_END         = TIME_W'(PED_S - 1);
  localparam logic [TIME_W-1:0] GREEN_END       = TIME_W'(GREEN_S - 1);
  localparam logic [TIME_W-1:0] GREEN_SHORT_END = TIME_W'(GREEN_S - PED_S - 1);
  localparam logic [TIME_W-1:0] YELLOW_END      = TIME_W'(YELLOW_S - 1);
  localparam logic [RW-1:0]     LAST_ROAD       = RW'(NUM_ROADS - 1);

  typedef enum logic [2:0] {
    ALL_RED     = 3'd0,
    LEFT_TURN   = 3'd1,
    GREEN_PEDES = 3'd2,
    GREEN       = 3'd3,
    YELLOW      = 3'd4,
    ISSUE       = 3'd5
  } state_t;

  state_t            state_reg, state_next;
  logic [RW-1:0]     road_reg, road_next;
  logic [PW-1:0]     presc_reg;
  logic [TIME_W-1:0] phase_cnt_reg;
  logic [FW-1:0]     flash_cnt_reg;
  logic              flash_reg;
  logic              ped_phase_reg, ped_phase_next;  // this turn's GREEN follows GREEN_PEDES
  logic              tick, phase_end, ped_take, ped_pending;
  logic [TIME_W-1:0] dur_end;

  assign tick = (presc_reg == TICK_LAST);

`ifdef TLS_PED_REQUEST_EN
  logic [NUM_ROADS-1:0] ped_latch_reg, ped_clear;

  assign ped_pending = ped_latch_reg[road_reg];

  for (genvar gi = 0; gi < NUM_ROADS; gi++) begin : g_ped_clear
    assign ped_clear[gi] = ped_take && (road_reg == RW'(gi));
  end

  // A request arriving on the clearing edge survives: set has priority over clear.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      ped_latch_reg <= '0;
    end else if (state_next != ISSUE) begin
      ped_latch_reg <= (ped_latch_reg & ~ped_clear) | in_ped_request;
    end
  end
`else
  assign ped_pending = 1'b1;
`endif

  always_comb begin
    state_next     = state_reg;
    road_next      = road_reg;
    ped_phase_next = ped_phase_reg;
    ped_take       = 1'b0;
    dur_end        = ALLRED_END;
    case (state_reg)
      LEFT_TURN:   dur_end = LEFT_END;
      GREEN_PEDES: dur_end = PED_END;
      GREEN:       dur_end = ped_phase_reg ? GREEN_SHORT_END : GREEN_END;
      YELLOW:      dur_end = YELLOW_END;
      default:     dur_end = ALLRED_END;
    endcase
    phase_end = tick && (phase_cnt_reg == dur_end);

    if (in_issue || state_reg == ISSUE) begin
      state_next = ISSUE;
    end else if (phase_end) begin
      case (state_reg)
        ALL_RED: state_next = LEFT_TURN;
        LEFT_TURN: begin
          if (ped_pending) begin
            state_next     = GREEN_PEDES;
            ped_take       = 1'b1;
            ped_phase_next = 1'b1;
          end else begin
            state_next     = GREEN;
            ped_phase_next = 1'b0;
          end
        end
        GREEN_PEDES: state_next = GREEN;
        GREEN:       state_next = YELLOW;
        YELLOW: begin
          state_next = ALL_RED;
          road_next  = (road_reg == LAST_ROAD) ? '0 : road_reg + RW'(1);
        end
        default: state_next = ALL_RED;
      endcase
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_reg     <= ALL_RED;
      road_reg      <= '0;
      presc_reg     <= '0;
      phase_cnt_reg <= '0;
      flash_cnt_reg <= '0;
      flash_reg     <= 1'b1;
      ped_phase_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      road_reg      <= road_next;
      ped_phase_reg <= ped_phase_next;
      if (state_next != state_reg) begin
        presc_reg     <= '0;
        phase_cnt_reg <= '0;
      end else begin
        presc_reg <= tick ? '0 : presc_reg + PW'(1);
        if (tick) phase_cnt_reg <= phase_cnt_reg + TIME_W'(1);
      end
      if (state_reg == ISSUE) begin
        if (flash_cnt_reg == FLASH_LAST) begin
          flash_cnt_reg <= '0;
          flash_reg     <= ~flash_reg;
        end else begin
          flash_cnt_reg <= flash_cnt_reg + FW'(1);
        end
      end else begin
        flash_cnt_reg <= '0;
        flash_reg     <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_ROADS; gi++) begin : g_lamps
    logic on, lit;
    assign on  = (road_reg == RW'(gi));
    assign lit = on && (state_reg == LEFT_TURN || state_reg == GREEN_PEDES ||
                        state_reg == GREEN || state_reg == YELLOW);
    assign out_left_turn[gi]  = on && (state_reg == LEFT_TURN);
    assign out_green[gi]      = on && (state_reg == GREEN_PEDES || state_reg == GREEN);
    assign out_pedestrian[gi] = on && (state_reg == GREEN_PEDES);
    assign out_yellow[gi]     = on && (state_reg == YELLOW);
    assign out_red[gi]        = (state_reg == ISSUE) ? flash_reg : !lit;
  end

  assign out_active_road = road_reg;
  assign out_state       = state_reg;
  assign out_fault       = (state_reg == ISSUE);
endmodule

// File: tb/tb_intersection_light_sequencer.sv
// Randomised self-checking bench: a cycle-countdown model of the light sequence
// predicts every lamp/status output of a 2-road and a 3-road instance.
module tb_intersection_light_sequencer;
  localparam int TD = 4;
  localparam int ALLRED_S = 1, LEFT_S = 2, PED_S = 2, GREEN_S = 4, YELLOW_S = 1;
  localparam int FLASH_DIV = 3;

  logic clk = 1'b0;
  logic rst_n, rst3_n, issue, issue3;
  logic [1:0] ped;
  logic [2:0] ped3;
  logic [1:0] red0, yel0, grn0, lft0, pd0;
  logic [0:0] road0;
  logic [2:0] st0, red3, yel3, grn3, lft3, pd3, st3;
  logic [1:0] road3;
  logic fault0, fault3;
  logic [31:0] obs0, obs3;
  int checks = 0;
  int errors = 0;

  // behavioural model state, index 0: 2-road instance, index 1: 3-road instance
  int m_phase[2], m_road[2], m_rem[2], m_fcnt[2];
  bit m_issue[2], m_flash[2];
  logic [2:0] m_pend[2];

  always #5 clk = ~clk;

  intersection_light_sequencer #(.NUM_ROADS(2), .TICK_DIV(TD), .TIME_W(8), .ALLRED_S(ALLRED_S),
    .LEFT_S(LEFT_S), .PED_S(PED_S), .GREEN_S(GREEN_S), .YELLOW_S(YELLOW_S), .FLASH_DIV(FLASH_DIV)) dut (
    .in_clock(clk), .in_reset_n(rst_n), .in_issue(issue),
`ifdef TLS_PED_REQUEST_EN
    .in_ped_request(ped),
`endif
    .out_red(red0), .out_yellow(yel0), .out_green(grn0), .out_left_turn(lft0),
    .out_pedestrian(pd0), .out_active_road(road0), .out_state(st0), .out_fault(fault0));

  intersection_light_sequencer #(.NUM_ROADS(3), .TICK_DIV(TD), .TIME_W(8), .ALLRED_S(ALLRED_S),
    .LEFT_S(LEFT_S), .PED_S(PED_S), .GREEN_S(GREEN_S), .YELLOW_S(YELLOW_S), .FLASH_DIV(FLASH_DIV)) dut3 (
    .in_clock(clk), .in_reset_n(rst3_n), .in_issue(issue3),
`ifdef TLS_PED_REQUEST_EN
    .in_ped_request(ped3),
`endif
    .out_red(red3), .out_yellow(yel3), .out_green(grn3), .out_left_turn(lft3),
    .out_pedestrian(pd3), .out_active_road(road3), .out_state(st3), .out_fault(fault3));

  assign obs0 = {11'd0, fault0, st0, 1'b0, road0, 1'b0, pd0, 1'b0, lft0, 1'b0, grn0, 1'b0, yel0, 1'b0, red0};
  assign obs3 = {11'd0, fault3, st3, road3, pd3, lft3, grn3, yel3, red3};

  function automatic void model_reset(input int k);
    m_phase[k] = 0; m_road[k] = 0; m_rem[k] = ALLRED_S * TD;
    m_issue[k] = 1'b0; m_flash[k] = 1'b1; m_fcnt[k] = 0; m_pend[k] = '0;
  endfunction

  // One clock edge of the specified behaviour, phase lengths in whole cycles.
  function automatic void model_step(input int k, input bit iss, input logic [2:0] req);
    int r = m_road[k];
    int nr = (k == 0) ? 2 : 3;
    bit take, clr;
    if (m_issue[k]) begin
      m_fcnt[k]++;
      if (m_fcnt[k] == FLASH_DIV) begin m_fcnt[k] = 0; m_flash[k] = !m_flash[k]; end
      return;
    end
    if (iss) begin m_issue[k] = 1'b1; m_flash[k] = 1'b1; m_fcnt[k] = 0; return; end
    clr = 1'b0;
    m_rem[k]--;
    if (m_rem[k] == 0) begin
      case (m_phase[k])
        0: begin m_phase[k] = 1; m_rem[k] = LEFT_S * TD; end
        1: begin
`ifdef TLS_PED_REQUEST_EN
          take = m_pend[k][r];
`else
          take = 1'b1;
`endif
          if (take) begin m_phase[k] = 2; m_rem[k] = PED_S * TD; clr = 1'b1; end
          else begin m_phase[k] = 3; m_rem[k] = GREEN_S * TD; end
        end
        2: begin m_phase[k] = 3; m_rem[k] = (GREEN_S - PED_S) * TD; end
        3: begin m_phase[k] = 4; m_rem[k] = YELLOW_S * TD; end
        default: begin m_phase[k] = 0; m_road[k] = (r + 1) % nr; m_rem[k] = ALLRED_S * TD; end
      endcase
    end
    if (clr) m_pend[k][r] = 1'b0;
    m_pend[k] = m_pend[k] | req;
  endfunction

  function automatic logic [31:0] exp_vec(input int k);
    logic [2:0] rd, yl, gn, lf, pd;
    int nr = (k == 0) ? 2 : 3;
    rd = '0; yl = '0; gn = '0; lf = '0; pd = '0;
    for (int i = 0; i < nr; i++) begin
      if (m_issue[k]) rd[i] = m_flash[k];
      else if (i == m_road[k] && m_phase[k] != 0) begin
        case (m_phase[k])
          1: lf[i] = 1'b1;
          2: begin gn[i] = 1'b1; pd[i] = 1'b1; end
          3: gn[i] = 1'b1;
          default: yl[i] = 1'b1;
        endcase
      end else rd[i] = 1'b1;
    end
    return {11'd0, m_issue[k], (m_issue[k] ? 3'd5 : 3'(m_phase[k])), 2'(m_road[k]), pd, lf, gn, yl, rd};
  endfunction

  // Advance one clock: inputs already driven are applied on the posedge, then return at the negedge.
  task automatic tick();
    bit iss0 = issue;
    logic [2:0] p0 = {1'b0, ped};
    @(posedge clk);
    if (rst_n) model_step(0, iss0, p0); else model_reset(0);
    if (rst3_n) model_step(1, issue3, ped3); else model_reset(1);
    @(negedge clk);
    ped = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst3_n = 1'b0; issue = 1'b0; issue3 = 1'b0; ped = '0; ped3 = '0;
    model_reset(0); model_reset(1);
    repeat (2) tick();
    checks++;
    if (red0 !== 2'b11 || grn0 !== 2'b00 || yel0 !== 2'b00 || lft0 !== 2'b00 || pd0 !== 2'b00) begin
      errors++; $display("FAIL reset_lamps: observed red=%b grn=%b yel=%b lft=%b ped=%b required red=11 others 00", red0, grn0, yel0, lft0, pd0);
    end
    checks++;
    if (road0 !== 1'b0 || st0 !== 3'd0 || fault0 !== 1'b0) begin
      errors++; $display("FAIL reset_status: observed road=%0d state=%0d fault=%b required 0 0 0", road0, st0, fault0);
    end
    rst_n = 1'b1; rst3_n = 1'b1;
  endtask

  task automatic test_no_request();
    int n_ar = 0, n_l = 0, n_g = 0, n_y = 0, n_p = 0;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (obs0 !== exp_vec(0)) begin errors++; $display("FAIL no_req_cycle%0d: observed %h required %h", i, obs0, exp_vec(0)); end
      if (i < 32) begin
        n_ar += (st0 == 3'd0) ? 1 : 0; n_l += int'(lft0[0]); n_g += int'(grn0[0]);
        n_y += int'(yel0[0]); n_p += int'(pd0[0]);
      end
      if (i == 32) begin
        checks++;
        if (road0 !== 1'b1 || st0 !== 3'd0) begin errors++; $display("FAIL no_req_handover: observed road=%0d state=%0d required 1 0", road0, st0); end
      end
      tick();
    end
    checks++;
    if (n_ar !== 4 || n_l !== 8 || n_g !== 16 || n_y !== 4) begin
      errors++; $display("FAIL no_req_durations: observed allred=%0d left=%0d green=%0d yellow=%0d required 4 8 16 4", n_ar, n_l, n_g, n_y);
    end
    checks++;
`ifdef TLS_PED_REQUEST_EN
    if (n_p !== 0) begin errors++; $display("FAIL no_req_ped: observed %0d walk cycles required 0", n_p); end
`else
    if (n_p !== 8) begin errors++; $display("FAIL no_req_ped: observed %0d walk cycles required 8", n_p); end
`endif
    checks++;
    if (road0 !== 1'b0 || st0 !== 3'd0) begin errors++; $display("FAIL no_req_loop: observed road=%0d state=%0d required 0 0", road0, st0); end
  endtask

  task automatic test_ped_request();
    int g = 0, l1 = 0, p1 = 0, g1 = 0, y1 = 0, p1b = 0;
    while (!(m_phase[0] == 3 && m_road[0] == 0) && g < 200) begin tick(); g++; end
    checks++;
    if (g >= 200) begin errors++; $display("FAIL ped_wait: observed no road0 green within 200 cycles, required one"); end
    ped = 2'b10;
    tick();
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (obs0 !== exp_vec(0)) begin errors++; $display("FAIL ped_cycle%0d: observed %h required %h", i, obs0, exp_vec(0)); end
      if (i < 64) begin l1 += int'(lft0[1]); p1 += int'(pd0[1]); g1 += int'(grn0[1]); y1 += int'(yel0[1]); end
      else p1b += int'(pd0[1]);
      tick();
    end
    checks++;
    if (l1 !== 8 || p1 !== 8 || g1 !== 16 || y1 !== 4) begin
      errors++; $display("FAIL ped_served: observed left=%0d walk=%0d green=%0d yellow=%0d required 8 8 16 4", l1, p1, g1, y1);
    end
    checks++;
`ifdef TLS_PED_REQUEST_EN
    if (p1b !== 0) begin errors++; $display("FAIL ped_cleared: observed %0d walk cycles next turn required 0", p1b); end
`else
    if (p1b !== 8) begin errors++; $display("FAIL ped_cleared: observed %0d walk cycles next turn required 8", p1b); end
`endif
  endtask

  task automatic test_issue();
    int g = 0;
    while (!(m_phase[0] == 3 && m_road[0] == 0) && g < 200) begin tick(); g++; end
    tick();
    issue = 1'b1;
    tick();
    checks++;
    if (st0 !== 3'd5 || fault0 !== 1'b1 || grn0 !== 2'b00 || red0 !== 2'b11) begin
      errors++; $display("FAIL issue_entry: observed state=%0d fault=%b grn=%b red=%b required 5 1 00 11", st0, fault0, grn0, red0);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (red0 !== 2'b00) begin errors++; $display("FAIL issue_flash: observed red=%b required 00", red0); end
    issue = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs0 !== exp_vec(0)) begin errors++; $display("FAIL issue_cycle%0d: observed %h required %h", i, obs0, exp_vec(0)); end
      tick();
    end
    checks++;
    if (st0 !== 3'd5) begin errors++; $display("FAIL issue_sticky: observed state=%0d required 5", st0); end
    rst_n = 1'b0;
    #1;
    model_reset(0);
    checks++;
    if (st0 !== 3'd0 || road0 !== 1'b0 || fault0 !== 1'b0 || red0 !== 2'b11) begin
      errors++; $display("FAIL issue_exit: observed state=%0d road=%0d fault=%b red=%b required 0 0 0 11", st0, road0, fault0, red0);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    int g = 0;
    while (!(m_phase[0] == 4 && m_road[0] == 1) && g < 200) begin
      checks++;
      if (obs0 !== exp_vec(0)) begin errors++; $display("FAIL areset_cycle%0d: observed %h required %h", g, obs0, exp_vec(0)); end
      tick(); g++;
    end
    tick();
    #2;
    checks++;
    if (yel0 !== 2'b10) begin errors++; $display("FAIL areset_pre: observed yellow=%b required 10", yel0); end
    rst_n = 1'b0;
    #1;
    model_reset(0);
    checks++;
    if (red0 !== 2'b11 || yel0 !== 2'b00 || road0 !== 1'b0 || st0 !== 3'd0) begin
      errors++; $display("FAIL areset_now: observed red=%b yellow=%b road=%0d state=%0d required 11 00 0 0", red0, yel0, road0, st0);
    end
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_ped_coincide();
    int g = 0, p0 = 0;
    ped = 2'b01;
    tick();
    while (!(m_phase[0] == 1 && m_road[0] == 0 && m_rem[0] == 1) && g < 100) begin tick(); g++; end
    ped = 2'b01;
    tick();
    checks++;
    if (pd0 !== 2'b01 || grn0 !== 2'b01) begin errors++; $display("FAIL coincide_now: observed walk=%b green=%b required 01 01", pd0, grn0); end
    for (int i = 0; i < 80; i++) begin
      checks++;
      if (obs0 !== exp_vec(0)) begin errors++; $display("FAIL coincide_cycle%0d: observed %h required %h", i, obs0, exp_vec(0)); end
      p0 += int'(pd0[0]);
      tick();
    end
    checks++;
    if (p0 !== 16) begin errors++; $display("FAIL coincide_next_turn: observed %0d walk cycles required 16", p0); end
  endtask

  task automatic test_wrap();
    int prev_phase, prev_road;
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      checks++;
      if (obs3 !== exp_vec(1)) begin errors++; $display("FAIL wrap_cycle%0d: observed %h required %h", i, obs3, exp_vec(1)); end
      prev_phase = m_phase[1]; prev_road = m_road[1];
      tick();
      if (prev_phase == 4 && prev_road == 2 && m_phase[1] == 0) begin
        seen = 1'b1;
        checks++;
        if (road3 !== 2'd0 || st3 !== 3'd0 || red3 !== 3'b111) begin
          errors++; $display("FAIL wrap_edge: observed road=%0d state=%0d red=%b required 0 0 111", road3, st3, red3);
        end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL wrap_seen: observed no road2 yellow end within 200 cycles, required one"); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) ped = 2'($urandom_range(1, 3));
      if (i == 590) issue = 1'b1;
      tick();
      checks++;
      if (obs0 !== exp_vec(0)) begin errors++; $display("FAIL random0_cycle%0d: observed %h required %h", i, obs0, exp_vec(0)); end
      checks++;
      if (obs3 !== exp_vec(1)) begin errors++; $display("FAIL random3_cycle%0d: observed %h required %h", i, obs3, exp_vec(1)); end
    end
    issue = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish by 1000000 time units, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_no_request();
    test_ped_request();
    test_issue();
    test_async_reset();
    test_ped_coincide();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
